// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-outstanding memory port between an instruction
// fetch requester and a data load/store requester. Data normally has priority,
// but a bounded streak of data grants forces a pending fetch through. A
// watchdog aborts transactions whose mem_ack never arrives.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned STREAK_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,      // asynchronous, active-low
    // fetch requester
    input  logic              i_f_req,
    input  logic [ADDR_W-1:0] i_f_addr,
    output logic              o_f_ack,
    output logic [31:0]       o_f_rdata,
    output logic              o_f_err,
    // data requester
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [31:0]       i_d_wdata,
    input  logic [3:0]        i_d_be,
    output logic              o_d_ack,
    output logic [31:0]       o_d_rdata,
    output logic              o_d_err,
    // unified memory port
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_be,
    input  logic              i_mem_ack,
    input  logic [31:0]       i_mem_rdata
);

    localparam int unsigned STREAK_W = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);
    localparam int unsigned WDOG_W   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_F = 2'd1,
        GRANT_D = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              r_state;
    logic [STREAK_W-1:0] r_streak;
    logic [WDOG_W-1:0]   r_wdog;
    logic                r_gnt_d;   // current transaction belongs to the data side
    logic                r_store;   // current data transaction is a store

    logic                w_streak_full;
    logic                w_pick_d;
    logic                w_pick_f;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_misalign;
    logic                w_wdog_expired;

    // Arbitration decision: data wins unless the fetch side has starved for STREAK_MAX grants
    assign w_streak_full  = (r_streak == STREAK_W'(STREAK_MAX));
    assign w_pick_d       = i_d_req && (!i_f_req || !w_streak_full);
    assign w_pick_f       = i_f_req && !w_pick_d;
    assign w_addr         = w_pick_d ? i_d_addr : i_f_addr;
    assign w_misalign     = (w_addr[1:0] != 2'b00);
    assign w_wdog_expired = (r_wdog == WDOG_W'(TIMEOUT - 1));

    // Arbiter FSM with registered memory-port and requester-response outputs
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_streak    <= '0;
            r_wdog      <= '0;
            r_gnt_d     <= 1'b0;
            r_store     <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_be    <= '0;
            o_f_ack     <= 1'b0;
            o_f_err     <= 1'b0;
            o_f_rdata   <= '0;
            o_d_ack     <= 1'b0;
            o_d_err     <= 1'b0;
            o_d_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_d || w_pick_f) begin
                        r_wdog  <= '0;
                        r_gnt_d <= w_pick_d;
                        r_store <= w_pick_d && i_d_we;

                        // Fetch grants reset the starvation count; data grants over a waiting fetch add to it
                        if (w_pick_f) begin
                            r_streak <= '0;
                        end else if (i_f_req && !w_streak_full) begin
                            r_streak <= r_streak + STREAK_W'(1);
                        end

                        if (w_misalign) begin
                            // Misaligned access never reaches memory; answer with an error directly
                            r_state <= RESP;
                            if (w_pick_d) begin
                                o_d_ack   <= 1'b1;
                                o_d_err   <= 1'b1;
                                o_d_rdata <= '0;
                            end else begin
                                o_f_ack   <= 1'b1;
                                o_f_err   <= 1'b1;
                                o_f_rdata <= '0;
                            end
                        end else begin
                            r_state    <= w_pick_d ? GRANT_D : GRANT_F;
                            o_mem_req  <= 1'b1;
                            o_mem_addr <= w_addr;
                            if (w_pick_d) begin
                                o_mem_we    <= i_d_we;
                                o_mem_be    <= i_d_be;
                                o_mem_wdata <= i_d_wdata;
                            end else begin
                                o_mem_we    <= 1'b0;
                                o_mem_be    <= 4'hF;
                                o_mem_wdata <= '0;
                            end
                        end
                    end
                end

                GRANT_F, GRANT_D: begin
                    if (i_mem_ack) begin
                        // Completion takes priority over a simultaneous watchdog expiry
                        o_mem_req <= 1'b0;
                        r_state   <= RESP;
                        if (r_gnt_d) begin
                            o_d_ack   <= 1'b1;
                            o_d_err   <= 1'b0;
                            o_d_rdata <= r_store ? 32'd0 : i_mem_rdata;
                        end else begin
                            o_f_ack   <= 1'b1;
                            o_f_err   <= 1'b0;
                            o_f_rdata <= i_mem_rdata;
                        end
                    end else if (w_wdog_expired) begin
                        // Memory never answered: abandon the request and report an error
                        o_mem_req <= 1'b0;
                        r_state   <= RESP;
                        if (r_gnt_d) begin
                            o_d_ack   <= 1'b1;
                            o_d_err   <= 1'b1;
                            o_d_rdata <= '0;
                        end else begin
                            o_f_ack   <= 1'b1;
                            o_f_err   <= 1'b1;
                            o_f_rdata <= '0;
                        end
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
                end

                RESP: begin
                    // Single-cycle response; no grant is considered here
                    o_f_ack   <= 1'b0;
                    o_f_err   <= 1'b0;
                    o_f_rdata <= '0;
                    o_d_ack   <= 1'b0;
                    o_d_err   <= 1'b0;
                    o_d_rdata <= '0;
                    r_state   <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset values, fetch/load/store transactions,
// streak arbitration, misaligned errors, watchdog timeout and mid-transaction reset.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 32;

    logic              clk;
    logic              rst_n;
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_ack;
    logic [31:0]       f_rdata;
    logic              f_err;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_be;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    int checks;
    int failures;

    mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .STREAK_MAX(4),
        .TIMEOUT   (8)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_f_req    (f_req),
        .i_f_addr   (f_addr),
        .o_f_ack    (f_ack),
        .o_f_rdata  (f_rdata),
        .o_f_err    (f_err),
        .i_d_req    (d_req),
        .i_d_we     (d_we),
        .i_d_addr   (d_addr),
        .i_d_wdata  (d_wdata),
        .i_d_be     (d_be),
        .o_d_ack    (d_ack),
        .o_d_rdata  (d_rdata),
        .o_d_err    (d_err),
        .o_mem_req  (mem_req),
        .o_mem_we   (mem_we),
        .o_mem_addr (mem_addr),
        .o_mem_wdata(mem_wdata),
        .o_mem_be   (mem_be),
        .i_mem_ack  (mem_ack),
        .i_mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1);
    end

    // Advance to 1ns after the next rising edge; inputs are driven and outputs sampled there
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        f_req = 0; f_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
        mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        checks++;
        if ({mem_req, mem_we, f_ack, d_ack, f_err, d_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000", {mem_req, mem_we, f_ack, d_ack, f_err, d_err});
        end
        checks++;
        if (mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem_addr got=%h exp=00000000", mem_addr);
        end
        checks++;
        if (mem_wdata !== 32'h0 || mem_be !== 4'h0) begin
            failures++;
            $display("FAIL reset_mem_wdata_be got=%h/%h exp=00000000/0", mem_wdata, mem_be);
        end
        checks++;
        if (f_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h/%h exp=0/0", f_rdata, d_rdata);
        end
        rst_n = 1;
        tick();
    endtask

    // Fetch at 0x100, memory answers in the 4th mem_req cycle
    task automatic test_fetch();
        do_reset();
        f_req = 1; f_addr = 32'h100;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
            failures++;
            $display("FAIL fetch_issue got req=%b addr=%h exp req=1 addr=00000100", mem_req, mem_addr);
        end
        checks++;
        if (mem_we !== 1'b0 || mem_be !== 4'hF) begin
            failures++;
            $display("FAIL fetch_we_be got we=%b be=%h exp we=0 be=f", mem_we, mem_be);
        end
        tick();
        tick();
        checks++;
        if (mem_req !== 1'b1 || f_ack !== 1'b0) begin
            failures++;
            $display("FAIL fetch_hold got req=%b ack=%b exp req=1 ack=0", mem_req, f_ack);
        end
        tick();
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 0; mem_rdata = '0;
        checks++;
        if (f_ack !== 1'b1 || f_rdata !== 32'hDEADBEEF || f_err !== 1'b0) begin
            failures++;
            $display("FAIL fetch_ack got ack=%b rdata=%h err=%b exp ack=1 rdata=deadbeef err=0", f_ack, f_rdata, f_err);
        end
        checks++;
        if (mem_req !== 1'b0 || d_ack !== 1'b0) begin
            failures++;
            $display("FAIL fetch_ack_side got mem_req=%b d_ack=%b exp 0/0", mem_req, d_ack);
        end
        f_req = 0;
        tick();
        checks++;
        if (f_ack !== 1'b0) begin
            failures++;
            $display("FAIL fetch_ack_once got=%b exp=0", f_ack);
        end
    endtask

    // Aligned store: memory port must carry the data-side we/be/wdata
    task automatic test_store();
        do_reset();
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678; d_be = 4'b0011;
        tick();
        checks++;
        if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h40 || mem_wdata !== 32'h12345678 || mem_be !== 4'b0011) begin
            failures++;
            $display("FAIL store_issue got req=%b we=%b addr=%h wdata=%h be=%b exp 1/1/00000040/12345678/0011",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_be);
        end
        mem_ack = 1;
        tick();
        mem_ack = 0;
        checks++;
        if (d_ack !== 1'b1 || d_err !== 1'b0 || f_ack !== 1'b0) begin
            failures++;
            $display("FAIL store_ack got d_ack=%b d_err=%b f_ack=%b exp 1/0/0", d_ack, d_err, f_ack);
        end
        d_req = 0; d_we = 0;
        tick();
    endtask

    // Both requesters held high, memory answers in the first mem_req cycle
    task automatic test_streak();
        bit exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int budget;
        do_reset();
        f_req = 1; f_addr = 32'h400;
        d_req = 1; d_we = 0; d_addr = 32'h800; d_be = 4'hF;
        for (int i = 0; i < 10; i++) begin
            budget = 0;
            while (mem_req !== 1'b1 && budget < 6) begin
                tick();
                budget++;
            end
            checks++;
            if (mem_addr !== (exp_d[i] ? 32'h800 : 32'h400) || mem_req !== 1'b1) begin
                failures++;
                $display("FAIL streak_grant%0d got req=%b addr=%h exp req=1 addr=%h",
                         i, mem_req, mem_addr, exp_d[i] ? 32'h800 : 32'h400);
            end
            mem_ack = 1; mem_rdata = 32'hA000_0000 + i;
            tick();
            mem_ack = 0;
            checks++;
            if ({d_ack, f_ack} !== (exp_d[i] ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL streak_ack%0d got d_ack=%b f_ack=%b exp d_ack=%b", i, d_ack, f_ack, exp_d[i]);
            end
        end
        f_req = 0; d_req = 0;
        tick();
    endtask

    // Misaligned data store and fetch: no memory access, error ack one cycle after grant
    task automatic test_misaligned();
        do_reset();
        d_req = 1; d_we = 1; d_addr = 32'h202; d_wdata = 32'h55AA55AA; d_be = 4'hF;
        tick();
        checks++;
        if (mem_req !== 1'b0 || d_ack !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL misalign_d got mem_req=%b d_ack=%b d_err=%b d_rdata=%h exp 0/1/1/0",
                     mem_req, d_ack, d_err, d_rdata);
        end
        d_req = 0; d_we = 0;
        tick();
        checks++;
        if (mem_req !== 1'b0 || d_ack !== 1'b0) begin
            failures++;
            $display("FAIL misalign_d_after got mem_req=%b d_ack=%b exp 0/0", mem_req, d_ack);
        end
        f_req = 1; f_addr = 32'h101;
        tick();
        checks++;
        if (mem_req !== 1'b0 || f_ack !== 1'b1 || f_err !== 1'b1 || f_rdata !== 32'h0) begin
            failures++;
            $display("FAIL misalign_f got mem_req=%b f_ack=%b f_err=%b f_rdata=%h exp 0/1/1/0",
                     mem_req, f_ack, f_err, f_rdata);
        end
        f_req = 0;
        tick();
    endtask

    // Watchdog expiry after 8 mem_req cycles, then mem_ack in the 8th cycle wins
    task automatic test_timeout();
        int high_cycles;
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h300; d_be = 4'hF;
        tick();
        high_cycles = 0;
        for (int k = 1; k <= 8; k++) begin
            if (mem_req === 1'b1 && d_ack === 1'b0) high_cycles++;
            tick();
        end
        checks++;
        if (high_cycles !== 8) begin
            failures++;
            $display("FAIL timeout_req_cycles got=%0d exp=8", high_cycles);
        end
        checks++;
        if (mem_req !== 1'b0 || d_ack !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL timeout_ack got mem_req=%b d_ack=%b d_err=%b d_rdata=%h exp 0/1/1/0",
                     mem_req, d_ack, d_err, d_rdata);
        end
        d_req = 0;
        tick();
        d_req = 1; d_addr = 32'h304;
        tick();
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) begin
                mem_ack = 1; mem_rdata = 32'hCAFEF00D;
            end
            tick();
        end
        mem_ack = 0; mem_rdata = '0;
        checks++;
        if (d_ack !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL timeout_ack_wins got d_ack=%b d_err=%b d_rdata=%h exp 1/0/cafef00d",
                     d_ack, d_err, d_rdata);
        end
        d_req = 0;
        tick();
    endtask

    // A stray mem_ack while idle must not produce any response
    task automatic test_idle_ack();
        do_reset();
        mem_ack = 1; mem_rdata = 32'h11111111;
        tick();
        mem_ack = 0;
        tick();
        checks++;
        if ({f_ack, d_ack, mem_req} !== 3'b000) begin
            failures++;
            $display("FAIL idle_ack got f_ack=%b d_ack=%b mem_req=%b exp 000", f_ack, d_ack, mem_req);
        end
    endtask

    // Reset during an outstanding load; a pending fetch is served afterwards
    task automatic test_reset_mid();
        int d_acks;
        do_reset();
        d_acks = 0;
        d_req = 1; d_we = 0; d_addr = 32'h500; d_be = 4'hF;
        tick();
        f_req = 1; f_addr = 32'h600;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin
            failures++;
            $display("FAIL rstmid_issue got req=%b addr=%h exp 1/00000500", mem_req, mem_addr);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_be, d_ack, f_ack} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs got req=%b addr=%h be=%h exp all zero", mem_req, mem_addr, mem_be);
        end
        d_req = 0;
        tick();
        tick();
        rst_n = 1;
        mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
        tick();
        mem_ack = 0; mem_rdata = '0;
        if (d_ack === 1'b1) d_acks++;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h600 || f_ack !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_fetch_issue got req=%b addr=%h f_ack=%b exp 1/00000600/0", mem_req, mem_addr, f_ack);
        end
        tick();
        if (d_ack === 1'b1) d_acks++;
        mem_ack = 1; mem_rdata = 32'h600DF00D;
        tick();
        mem_ack = 0; mem_rdata = '0;
        if (d_ack === 1'b1) d_acks++;
        checks++;
        if (f_ack !== 1'b1 || f_rdata !== 32'h600DF00D || f_err !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_fetch_ack got ack=%b rdata=%h err=%b exp 1/600df00d/0", f_ack, f_rdata, f_err);
        end
        f_req = 0;
        tick();
        if (d_ack === 1'b1) d_acks++;
        tick();
        if (d_ack === 1'b1) d_acks++;
        checks++;
        if (d_acks !== 0) begin
            failures++;
            $display("FAIL rstmid_no_d_ack got=%0d exp=0", d_acks);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 0;
        clear_inputs();
        test_reset();
        test_fetch();
        test_store();
        test_streak();
        test_misaligned();
        test_timeout();
        test_idle_ack();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of all ports.
REQ-002 Parameter STREAK_MAX, default 4: maximum consecutive data grants while a fetch is pending.
REQ-003 Parameter TIMEOUT, default 255: number of cycles to wait for mem_ack before aborting; legal range 1..65535.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 f_req  input  1  fetch request; held high until f_ack.
REQ-007 f_addr  input  ADDR_W  fetch word address; held stable while f_req is high.
REQ-008 f_ack  output  1  one-cycle fetch completion pulse.
REQ-009 f_rdata  output  32  fetched word; valid only in the f_ack cycle.
REQ-010 d_req, d_we  input  1 each  data request and write enable; both held until d_ack.
REQ-011 d_addr, d_wdata, d_be  input  ADDR_W, 32, 4  data address, store data and byte enables; held while d_req is high.
REQ-012 d_ack  output  1  one-cycle data completion pulse.
REQ-013 d_rdata  output  32  load data; valid only in the d_ack cycle.
REQ-014 d_err, f_err  output  1 each  error flag qualified by the matching ack.
REQ-015 mem_req, mem_we  output  1 each  unified memory request and write enable.
REQ-016 mem_addr, mem_wdata, mem_be  output  ADDR_W, 32, 4  unified memory address, write data and byte enables.
REQ-017 mem_ack  input  1  one-cycle memory completion; mem_rdata valid in the same cycle.
REQ-018 mem_rdata  input  32  memory read data.

Function
REQ-019 The FSM SHALL have the states IDLE, GRANT_F, GRANT_D and RESP; exactly one memory transaction is outstanding at a time.
REQ-020 Arbitration in IDLE SHALL follow these rules:
- If only one requester is high, that requester is granted.
- If both are high, data is granted unless streak==STREAK_MAX, in which case fetch is granted.
REQ-021 streak SHALL behave as follows:
- It increments (saturating at STREAK_MAX) on each data grant made while f_req is high.
- It clears on any fetch grant.
- It is otherwise unchanged.
REQ-022 On a grant decision in IDLE at cycle N, the registered mem_* outputs SHALL be driven from cycle N+1 and stay constant until mem_ack.
- Fetch grant drives mem_we=0 and mem_be=4'hF.
- Data grant copies d_we, d_be and d_wdata.
REQ-023 A granted address with addr[1:0]!=0 SHALL NOT issue mem_req; the FSM goes directly to RESP with err=1 and rdata=0.
REQ-024 In GRANT_x, mem_ack SHALL cause:
- mem_rdata to be latched (loads and fetches only);
- mem_req to drop at the next edge;
- a transition to RESP.
REQ-025 In RESP, for exactly one cycle, the arbiter SHALL assert the matching x_ack with the latched rdata and err, then return to IDLE; no grant is made in RESP.
REQ-026 Latency SHALL be as follows:
- Request seen at cycle N, mem_ack at cycle M gives x_ack at M+1.
- Minimum is N+2, when mem_ack arrives in the first mem_req cycle.
REQ-027 A watchdog counter SHALL clear on each grant and increment every cycle in GRANT_x.
- When it reaches TIMEOUT without mem_ack, the arbiter drops mem_req and enters RESP with err=1 and rdata=0.
REQ-028 If mem_ack and the timeout coincide in the same cycle, mem_ack SHALL win: err=0 and the data is returned.
REQ-029 mem_ack arriving in IDLE or RESP SHALL be ignored.
REQ-030 f_ack and d_ack SHALL never be high in the same cycle, and at most one ack SHALL occur per grant.
REQ-031 Requests that drop before their grant SHALL be ignored; inputs are sampled only at grant time.

Reset
REQ-032 While reset is low, all of the following SHALL hold:
- state=IDLE;
- streak=0 and watchdog=0;
- mem_req, mem_we, f_ack, d_ack, f_err, d_err = 0;
- mem_addr, mem_wdata, f_rdata, d_rdata = 0 and mem_be = 0.
REQ-033 Reset asserted mid-transaction SHALL abandon that transaction with no ack; a mem_ack in the first cycle after reset release is ignored.

Verification
REQ-034 Scenario 1: f_req with f_addr=0x100; mem_ack 3 cycles after mem_req with mem_rdata=0xDEADBEEF -> f_ack one cycle later, f_rdata=0xDEADBEEF, f_err=0, mem_we=0, mem_be=4'hF.
REQ-035 Scenario 2: f_req and d_req held high continuously with STREAK_MAX=4 and 1-cycle memory -> grant order D,D,D,D,F,D,D,D,D,F.
REQ-036 Scenario 3: d_req store with d_addr=0x202 -> no mem_req; d_ack 1 cycle after grant with d_err=1.
REQ-037 Scenario 4: TIMEOUT=8 and mem_ack never arrives -> mem_req high for 8 cycles; d_ack with d_err=1 and d_rdata=0. Repeat with mem_ack in cycle 8 -> d_err=0 and data returned.
REQ-038 Scenario 5: reset pulled low while mem_req is high for a load -> all outputs 0 immediately; after release, a pending f_req is served normally and no d_ack is ever produced for the aborted load.
